// File: rtl/ctrl_pkg.sv
// Shared control-path types and encodings for the pipelined RISC-V core.
// Bundle fields are sized for the widest supported ALUOp/rd; narrower settings zero-extend.
package ctrl_pkg;

    localparam int ALUOP_FIELD_W = 4;
    localparam int RD_FIELD_W    = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef struct packed {
        logic [ALUOP_FIELD_W-1:0] aluop;
        logic                     alusrc;
        logic                     branch;
        logic                     jump;
        logic                     memread;
        logic                     memwrite;
        logic                     regwrite;
        logic [1:0]               memtoreg;
        logic [RD_FIELD_W-1:0]    rd;
        logic                     valid;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundle, illegal flag and source-register usage.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5,
    parameter int ALUOP_W   = 2,
    parameter bit JUMP_EN   = 1'b1
) (
    input  logic [31:0]          instr,
    output ctrl_bundle_t         ctrl,
    output logic                 illegal,
    output logic                 use_rs1,
    output logic                 use_rs2,
    output logic [REG_IDX_W-1:0] rs1,
    output logic [REG_IDX_W-1:0] rs2
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign rs1         = instr[15 +: REG_IDX_W];
    assign rs2         = instr[20 +: REG_IDX_W];
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    // Narrow ALUOp settings truncate to ALUOP_W first, then zero-extend into the bundle field.
    function automatic logic [ALUOP_FIELD_W-1:0] aluop_ext(input logic [1:0] code);
        logic [ALUOP_W-1:0] narrow;
        narrow = ALUOP_W'(code);
        return ALUOP_FIELD_W'(narrow);
    endfunction

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.aluop    = aluop_ext(ALUOP_R);
                ctrl.regwrite = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_I_ALU: begin
                ctrl.aluop    = aluop_ext(ALUOP_I);
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.aluop    = aluop_ext(ALUOP_ADD);
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = MTR_MEM;
                use_rs1       = 1'b1;
            end
            OP_STORE: begin
                ctrl.aluop    = aluop_ext(ALUOP_ADD);
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.aluop  = aluop_ext(ALUOP_BRANCH);
                ctrl.branch = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_JAL: begin
                if (JUMP_EN) begin
                    ctrl.jump     = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.memtoreg = MTR_PC4;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (JUMP_EN) begin
                    ctrl.aluop    = aluop_ext(ALUOP_ADD);
                    ctrl.alusrc   = 1'b1;
                    ctrl.jump     = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.memtoreg = MTR_PC4;
                    use_rs1       = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        ctrl.valid = !illegal;
        // rd is only meaningful for writers; stores and branches reuse those bits as immediate.
        if (ctrl.regwrite) begin
            ctrl.rd = RD_FIELD_W'(instr[7 +: REG_IDX_W]);
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control path for the pipelined core: decode in ID, then ID/EX, EX/MEM and MEM/WB control
// registers with stall, flush and load-use bubble handling.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5,
    parameter int ALUOP_W   = 2,
    parameter bit JUMP_EN   = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  instr_i,
    input  logic         id_valid_i,
    input  logic         stall_i,
    input  logic         flush_i,
    output ctrl_bundle_t ex_ctrl_o,
    output ctrl_bundle_t mem_ctrl_o,
    output ctrl_bundle_t wb_ctrl_o,
    output logic         hazard_stall_o,
    output logic         illegal_o
);

    ctrl_bundle_t         dec_ctrl;
    logic                 dec_illegal;
    logic                 dec_use_rs1;
    logic                 dec_use_rs2;
    logic [REG_IDX_W-1:0] dec_rs1;
    logic [REG_IDX_W-1:0] dec_rs2;

    ctrl_bundle_t ex_p0;
    ctrl_bundle_t mem_p1;
    ctrl_bundle_t wb_p2;
    logic         illegal_p0;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    ctrl_decode #(
        .REG_IDX_W (REG_IDX_W),
        .ALUOP_W   (ALUOP_W),
        .JUMP_EN   (JUMP_EN)
    ) u_decode (
        .instr   (instr_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2)
    );

    // Load-use: a load in EX whose (nonzero) destination feeds a source the ID instruction reads.
    assign rs1_hit = dec_use_rs1 && (RD_FIELD_W'(dec_rs1) == ex_p0.rd);
    assign rs2_hit = dec_use_rs2 && (RD_FIELD_W'(dec_rs2) == ex_p0.rd);
    assign hazard  = ex_p0.valid && ex_p0.memread && (ex_p0.rd != '0) &&
                     id_valid_i && (rs1_hit || rs2_hit);

    // ID -> EX -> MEM -> WB stage registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_p0      <= CTRL_BUBBLE;
            mem_p1     <= CTRL_BUBBLE;
            wb_p2      <= CTRL_BUBBLE;
            illegal_p0 <= 1'b0;
        end else if (stall_i) begin
            illegal_p0 <= 1'b0;
        end else begin
            mem_p1     <= ex_p0;
            wb_p2      <= mem_p1;
            illegal_p0 <= 1'b0;
            if (flush_i || hazard || !id_valid_i) begin
                ex_p0 <= CTRL_BUBBLE;
            end else begin
                // An illegal opcode decodes to the all-zero bundle, so it enters EX as a bubble.
                ex_p0      <= dec_ctrl;
                illegal_p0 <= dec_illegal;
            end
        end
    end

    assign ex_ctrl_o      = ex_p0;
    assign mem_ctrl_o     = mem_p1;
    assign wb_ctrl_o      = wb_p2;
    assign hazard_stall_o = hazard;
    assign illegal_o      = illegal_p0;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: decode vector table, hand-written hazard/stall/flush/reset sequences,
// and random traffic against a rule-table reference model, on JUMP_EN=1 and JUMP_EN=0 copies.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        stall;
    logic        flush;

    ctrl_bundle_t ex1, mem1, wb1, ex0, mem0, wb0;
    logic         haz1, ill1, haz0, ill0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_IDX_W(5), .ALUOP_W(2), .JUMP_EN(1'b1)) dut_j1 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .id_valid_i(id_valid),
        .stall_i(stall), .flush_i(flush), .ex_ctrl_o(ex1), .mem_ctrl_o(mem1),
        .wb_ctrl_o(wb1), .hazard_stall_o(haz1), .illegal_o(ill1)
    );

    ctrl_pipe #(.REG_IDX_W(5), .ALUOP_W(2), .JUMP_EN(1'b0)) dut_j0 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .id_valid_i(id_valid),
        .stall_i(stall), .flush_i(flush), .ex_ctrl_o(ex0), .mem_ctrl_o(mem0),
        .wb_ctrl_o(wb0), .hazard_stall_o(haz0), .illegal_o(ill0)
    );

    int total = 0;
    int bad   = 0;

    // Reference decode rules, one row per legal opcode.
    typedef struct {
        logic [6:0] op;
        logic [3:0] aluop;
        logic       alusrc, branch, jump, memread, memwrite, regwrite;
        logic [1:0] mtr;
        bit         u1, u2, needs_jump;
    } rule_t;
    rule_t rules[7];

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  aluop;
        logic [5:0]  flags;
        logic [1:0]  mtr;
        bit          v1, v0;
    } vec_t;
    vec_t vecs[8];

    logic [6:0] ops[8];

    ctrl_bundle_t mp[2][3];
    bit           mill[2];

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1, input int r2);
        return {7'b0, 5'(r2), 5'(r1), 3'b000, 5'(rd), op};
    endfunction

    function automatic void mdec(input logic [31:0] ins, input bit je, output ctrl_bundle_t b,
                                 output bit u1, output bit u2, output bit ill);
        b = '0; u1 = 0; u2 = 0; ill = 1;
        foreach (rules[k]) begin
            if (rules[k].op == ins[6:0] && (je || !rules[k].needs_jump)) begin
                b.aluop    = rules[k].aluop;
                b.alusrc   = rules[k].alusrc;
                b.branch   = rules[k].branch;
                b.jump     = rules[k].jump;
                b.memread  = rules[k].memread;
                b.memwrite = rules[k].memwrite;
                b.regwrite = rules[k].regwrite;
                b.memtoreg = rules[k].mtr;
                b.valid    = 1'b1;
                if (rules[k].regwrite) b.rd = ins[11:7];
                u1 = rules[k].u1; u2 = rules[k].u2; ill = 0;
            end
        end
    endfunction

    function automatic bit mhaz(input int j);
        ctrl_bundle_t d, e;
        bit u1, u2, il;
        mdec(instr, j == 1, d, u1, u2, il);
        e = mp[j][0];
        return e.valid && e.memread && (e.rd != 0) && id_valid &&
               ((u1 && instr[19:15] == e.rd) || (u2 && instr[24:20] == e.rd));
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int s = 0; s < 3; s++) mp[j][s] = '0;
            mill[j] = 0;
        end
    endtask

    task automatic model_edge();
        for (int j = 0; j < 2; j++) begin
            ctrl_bundle_t d;
            bit u1, u2, il, hz;
            if (rst) begin
                for (int s = 0; s < 3; s++) mp[j][s] = '0;
                mill[j] = 0;
            end else if (stall) begin
                mill[j] = 0;
            end else begin
                hz = mhaz(j);
                mdec(instr, j == 1, d, u1, u2, il);
                mp[j][2] = mp[j][1];
                mp[j][1] = mp[j][0];
                mill[j]  = 0;
                if (flush || hz || !id_valid) mp[j][0] = '0;
                else begin
                    mp[j][0] = d;
                    mill[j]  = il;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic compare_all();
        chk("ex_j1",  64'(ex1),  64'(mp[1][0]));
        chk("mem_j1", 64'(mem1), 64'(mp[1][1]));
        chk("wb_j1",  64'(wb1),  64'(mp[1][2]));
        chk("haz_j1", 64'(haz1), 64'(mhaz(1)));
        chk("ill_j1", 64'(ill1), 64'(mill[1]));
        chk("ex_j0",  64'(ex0),  64'(mp[0][0]));
        chk("mem_j0", 64'(mem0), 64'(mp[0][1]));
        chk("wb_j0",  64'(wb0),  64'(mp[0][2]));
        chk("haz_j0", 64'(haz0), 64'(mhaz(0)));
        chk("ill_j0", 64'(ill0), 64'(mill[0]));
    endtask

    // Check against the model on the falling edge, then advance the model with the DUT.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_bundle_t rb, sb;
        bit u1, u2, il;
        logic [17:0] want;
        logic [4:0]  vrd;

        rules[0] = '{OP_R,      4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        rules[1] = '{OP_I_ALU,  4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
        rules[2] = '{OP_LOAD,   4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        rules[3] = '{OP_STORE,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        rules[4] = '{OP_BRANCH, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        rules[5] = '{OP_JAL,    4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
        rules[6] = '{OP_JALR,   4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1};

        // flags = {alusrc, branch, jump, memread, memwrite, regwrite}
        vecs[0] = '{mk(OP_R, 6, 5, 7),      4'd2, 6'b000001, 2'd0, 1'b1, 1'b1};
        vecs[1] = '{mk(OP_I_ALU, 3, 2, 0),  4'd3, 6'b100001, 2'd0, 1'b1, 1'b1};
        vecs[2] = '{mk(OP_LOAD, 5, 1, 0),   4'd0, 6'b100101, 2'd1, 1'b1, 1'b1};
        vecs[3] = '{mk(OP_STORE, 9, 1, 4),  4'd0, 6'b100010, 2'd0, 1'b1, 1'b1};
        vecs[4] = '{mk(OP_BRANCH, 8, 1, 2), 4'd1, 6'b010000, 2'd0, 1'b1, 1'b1};
        vecs[5] = '{mk(OP_JAL, 1, 0, 0),    4'd0, 6'b001001, 2'd2, 1'b1, 1'b0};
        vecs[6] = '{mk(OP_JALR, 1, 3, 0),   4'd0, 6'b101001, 2'd2, 1'b1, 1'b0};
        vecs[7] = '{mk(7'b1111111, 4, 1, 2), 4'd0, 6'b000000, 2'd0, 1'b0, 1'b0};

        ops = '{OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, 7'b0001011};

        rst = 1'b1; instr = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        model_reset();
        cycle();
        chk("reset_ex_valid", 64'(ex1.valid), 64'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // Decode vector table
        for (int v = 0; v < 8; v++) begin
            instr = vecs[v].instr; id_valid = 1'b1;
            cycle();
            vrd  = vecs[v].flags[0] ? vecs[v].instr[11:7] : 5'd0;
            want = {vecs[v].aluop, vecs[v].flags, vecs[v].mtr, vrd, 1'b1};
            chk($sformatf("vec%0d_ex_j1", v), 64'(ex1), vecs[v].v1 ? 64'(want) : 64'd0);
            chk($sformatf("vec%0d_ex_j0", v), 64'(ex0), vecs[v].v0 ? 64'(want) : 64'd0);
            chk($sformatf("vec%0d_ill_j1", v), 64'(ill1), 64'(!vecs[v].v1));
            chk($sformatf("vec%0d_ill_j0", v), 64'(ill0), 64'(!vecs[v].v0));
            id_valid = 1'b0;
            cycle();
            chk($sformatf("vec%0d_ill_pulse_end", v), 64'(ill0), 64'd0);
        end

        // R add, store, idle: the add reaches WB two edges after EX; the store never writes.
        instr = mk(OP_R, 6, 5, 7); id_valid = 1'b1;
        mdec(instr, 1'b1, rb, u1, u2, il);
        cycle();
        instr = mk(OP_STORE, 0, 1, 6);
        mdec(instr, 1'b1, sb, u1, u2, il);
        cycle();
        id_valid = 1'b0;
        cycle();
        chk("r_add_wb", 64'(wb1), 64'(rb));
        chk("store_mem", 64'(mem1), 64'(sb));
        chk("store_no_regwrite", 64'(mem1.regwrite), 64'd0);
        cycle();

        // Load-use: exactly one bubble, then the add enters EX.
        instr = mk(OP_LOAD, 5, 1, 0); id_valid = 1'b1;
        cycle();
        instr = mk(OP_R, 6, 5, 7);
        #1 chk("lu_haz_on", 64'(haz1), 64'd1);
        cycle();
        chk("lu_bubble", 64'(ex1.valid), 64'd0);
        chk("lu_load_mem", 64'(mem1.memread), 64'd1);
        chk("lu_haz_off", 64'(haz1), 64'd0);
        cycle();
        chk("lu_add_ex_rd", 64'(ex1.rd), 64'd6);
        chk("lu_add_ex_valid", 64'(ex1.valid), 64'd1);
        id_valid = 1'b0;
        cycle();

        // Load to x0 never stalls.
        instr = mk(OP_LOAD, 0, 1, 0); id_valid = 1'b1;
        cycle();
        instr = mk(OP_R, 1, 0, 0);
        #1 chk("x0_no_haz", 64'(haz1), 64'd0);
        cycle();
        chk("x0_add_ex", 64'(ex1.rd), 64'd1);
        id_valid = 1'b0;
        cycle();

        // Hazard with flush: single bubble, then a dependent target instruction flows at once.
        instr = mk(OP_LOAD, 5, 1, 0); id_valid = 1'b1;
        cycle();
        instr = mk(OP_R, 6, 5, 7); flush = 1'b1;
        #1 chk("fl_haz_seen", 64'(haz1), 64'd1);
        cycle();
        flush = 1'b0;
        instr = mk(OP_R, 9, 5, 5);
        chk("fl_bubble", 64'(ex1.valid), 64'd0);
        #1 chk("fl_haz_dropped", 64'(haz1), 64'd0);
        cycle();
        chk("fl_target_ex", 64'(ex1.rd), 64'd9);
        id_valid = 1'b0;
        cycle();

        // stall_i held three cycles mid-stream.
        instr = mk(OP_R, 10, 1, 2); id_valid = 1'b1;
        cycle();
        instr = mk(OP_R, 11, 1, 2);
        cycle();
        instr = mk(OP_R, 12, 1, 2); stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("stall%0d_ex", k), 64'(ex1.rd), 64'd11);
            chk($sformatf("stall%0d_mem", k), 64'(mem1.rd), 64'd10);
        end
        stall = 1'b0;
        cycle();
        chk("resume_ex", 64'(ex1.rd), 64'd12);
        chk("resume_mem", 64'(mem1.rd), 64'd11);
        chk("resume_wb", 64'(wb1.rd), 64'd10);

        // Asynchronous reset mid-sequence.
        instr = mk(OP_LOAD, 3, 1, 0);
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_ex", 64'(ex1), 64'd0);
        chk("arst_mem", 64'(mem1), 64'd0);
        chk("arst_wb", 64'(wb1), 64'd0);
        chk("arst_haz", 64'(haz1), 64'd0);
        chk("arst_ill", 64'(ill0), 64'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        id_valid = 1'b0;
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            instr = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
            id_valid = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 6) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            cycle();
        end
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control path for the RISC-V pipelined core. It decodes the full 7-bit opcode of the instruction in ID. It carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers, handling stall, flush and load-use bubble insertion itself. It replaces per-stage control latching in the datapath: the datapath reads EX, MEM and WB control only from this block's outputs.

## Interface
- REG_IDX_W, 5: register index width (rd/rs1/rs2).
- ALUOP_W, 2: ALUOp field width; values above 2 zero-extend the encodings below.
- JUMP_EN, 1: 1 enables JAL/JALR decoding; 0 treats them as illegal.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_i  in  32  instruction in ID (opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20]).
- id_valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  external freeze (memory wait); holds all three stage registers.
- flush_i  in  1  taken branch/jump resolved in EX; kills the instruction in ID.
- ex_ctrl_o, mem_ctrl_o, wb_ctrl_o  out  bundle  control for each stage: ALUOp, ALUSrc, Branch, Jump, MemRead, MemWrite, RegWrite, MemtoReg[1:0], rd, valid.
- hazard_stall_o  out  1  load-use detected; datapath holds PC and IF/ID this cycle.
- illegal_o  out  1  registered one-cycle pulse: an unknown opcode entered EX as a bubble.

## Operation
- Decode, combinational on instr_i:
  - 0110011 R: ALUOp 10, RegWrite.
  - 0010011 I-ALU: ALUOp 11, ALUSrc, RegWrite.
  - 0000011 load: ALUOp 00, ALUSrc, MemRead, RegWrite, MemtoReg 01.
  - 0100011 store: ALUOp 00, ALUSrc, MemWrite.
  - 1100011 branch: ALUOp 01, Branch.
  - 1101111 JAL / 1100111 JALR (JUMP_EN=1): Jump, RegWrite, MemtoReg 10; JALR also sets ALUSrc, ALUOp 00.
  - Any other opcode: all-zero bundle, illegal flag set.
- Bubble: all-zero bundle with valid=0. A bubble never asserts MemWrite or RegWrite.
- rs2 is used only by R, store and branch. rs1 is used by all except JAL.
- Load-use: hazard_stall_o=1 when all of the following hold:
  - ex_ctrl_o.valid and ex_ctrl_o.MemRead;
  - ex rd != 0;
  - ex rd equals a used source of the ID instruction;
  - id_valid_i.
- Per-edge priority:
  1. stall_i: all stages hold; illegal_o=0.
  2. flush_i: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  3. hazard: ID/EX loads a bubble; the others advance.
  4. Normal: ID/EX loads decode if id_valid_i, else a bubble; all stages advance.
- illegal_o is set only in the normal case with an illegal opcode and id_valid_i=1.

## Timing
- Reset: every bundle is all-zero with valid=0; hazard_stall_o follows its combinational equation (0, since EX is invalid); illegal_o=0. Takes effect immediately and asynchronously; reset mid-stream discards all in-flight state.
- Latency from instruction in ID at edge N:
  - ex_ctrl_o after N;
  - mem_ctrl_o after N+1;
  - wb_ctrl_o after N+2.
  - Each stall_i cycle adds one.
- hazard_stall_o is combinational, valid in the same cycle the ID instruction is presented. One load-use produces exactly one bubble, since the load advances to MEM next edge.
- stall_i and hazard together: stall wins. The hazard re-evaluates after stall_i drops.
- flush_i and hazard together: flush wins. Exactly one bubble; no extra stall cycle.
- rd=0 load never causes a hazard.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams;
  - ALUOp codes (00 add, 01 branch compare, 10 R funct, 11 I funct);
  - MemtoReg codes (00 ALU, 01 mem, 10 PC+4);
  - ctrl_bundle_t struct;
  - CTRL_BUBBLE constant.
- Sub-module ctrl_decode is the pure combinational decoder, instantiated once. Stage registers and hazard logic stay in ctrl_pipe.

## Test plan
- R add then store, then idle: ex_ctrl_o shows ALUOp 10/RegWrite. Two cycles later wb_ctrl_o matches. The store never sets RegWrite.
- lw x5 followed by add x6,x5,x7: hazard_stall_o=1 for one cycle. ID/EX gets a bubble. The add enters EX the following edge.
- lw x0 followed by use of x0: hazard_stall_o stays 0.
- Hazard and flush_i in the same cycle: single bubble; hazard_stall_o effect is dropped by the next edge.
- stall_i held 3 cycles mid-stream: all three bundles frozen. Sequence resumes with no loss or duplication.
- JUMP_EN=0 with JAL opcode: bubble in EX, illegal_o pulses for one cycle. JUMP_EN=1: Jump=1, MemtoReg=10. Assert rst_i mid-sequence: all outputs zero immediately.
